// File: rtl/spi_oversample_rx.sv
// Oversampled SPI slave: receives 32-bit words from the PIC and commits them to q on VGA vsync.
// Build option: define SPI_PARITY_EN to reject received words with odd parity.
module spi_oversample_rx #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [15:0] TIMEOUT      = 16'd1000,
  parameter logic [3:0]  STALE_FRAMES = 4'd8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        sck,
  input  logic        sdo,
  input  logic        vsync,
  input  logic [31:0] d,
  output logic        sdi,
  output logic [31:0] q,
  output logic        q_valid,
  output logic        stale,
  output logic [7:0]  err_cnt
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned STALE_W = 4;
  localparam int unsigned ERR_W   = 8;

  logic [SYNC_STAGES-1:0] sck_sync, sdo_sync, vs_sync;
  logic                   sck_prev, vs_prev;

  logic [WORD_W-1:0]  rx_q, rx_nxt;
  logic [WORD_W-1:0]  tx_q, tx_nxt;
  logic [WORD_W-1:0]  pend_q, pend_nxt;
  logic               pend_full_q, pend_full_nxt;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
  logic [TMO_W-1:0]   tmo_q, tmo_nxt;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [WORD_W-1:0]  q_nxt;
  logic               q_valid_nxt;
  logic               stale_nxt;

  logic               sck_s, sdo_s, vs_s;
  logic               sck_fall_c, vs_start_c;
  logic [WORD_W-1:0]  rx_word_c;
  logic               word_ok_c;
  logic               err_inc_c;

  // Metastability synchronizers for the asynchronous PIC and VGA inputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sck_sync <= '0;
      sdo_sync <= '0;
      vs_sync  <= '0;
      sck_prev <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      sck_sync[0] <= sck;
      sdo_sync[0] <= sdo;
      vs_sync[0]  <= vsync;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sck_sync[i] <= sck_sync[i-1];
        sdo_sync[i] <= sdo_sync[i-1];
        vs_sync[i]  <= vs_sync[i-1];
      end
      sck_prev <= sck_sync[SYNC_STAGES-1];
      vs_prev  <= vs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign sdo_s      = sdo_sync[SYNC_STAGES-1];
  assign vs_s       = vs_sync[SYNC_STAGES-1];
  assign sck_fall_c = sck_prev & ~sck_s;
  assign vs_start_c = vs_prev & ~vs_s;
  assign rx_word_c  = {rx_q[WORD_W-2:0], sdo_s};

`ifdef SPI_PARITY_EN
  assign word_ok_c = ~^rx_word_c;
`else
  assign word_ok_c = 1'b1;
`endif

  // Next-state logic for shift registers, pending buffer, commit and status counters
  always_comb begin
    rx_nxt        = rx_q;
    tx_nxt        = tx_q;
    pend_nxt      = pend_q;
    pend_full_nxt = pend_full_q;
    bit_cnt_nxt   = bit_cnt_q;
    tmo_nxt       = tmo_q;
    stale_cnt_nxt = stale_cnt_q;
    err_nxt       = err_cnt;
    q_nxt         = q;
    q_valid_nxt   = 1'b0;
    err_inc_c     = 1'b0;

    if (sck_fall_c) begin
      tmo_nxt = '0;
    end else if (tmo_q != '1) begin
      tmo_nxt = tmo_q + TMO_W'(1);
    end

    if (sck_fall_c) begin
      rx_nxt      = rx_word_c;
      bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
      tx_nxt      = {tx_q[WORD_W-2:0], 1'b0};
    end else if (bit_cnt_q == '0) begin
      tx_nxt = d;
    end else if (tmo_q == TIMEOUT) begin
      bit_cnt_nxt = '0;
      rx_nxt      = '0;
      err_inc_c   = 1'b1;
    end

    if (vs_start_c) begin
      if (pend_full_q) begin
        q_nxt         = pend_q;
        q_valid_nxt   = 1'b1;
        pend_full_nxt = 1'b0;
        stale_cnt_nxt = '0;
      end else if (stale_cnt_q < STALE_FRAMES) begin
        stale_cnt_nxt = stale_cnt_q + STALE_W'(1);
      end
    end

    // A word finishing alongside vsync start lands after the commit of the older word
    if (sck_fall_c && bit_cnt_q == CNT_W'(WORD_W - 1)) begin
      if (word_ok_c) begin
        pend_nxt      = rx_word_c;
        pend_full_nxt = 1'b1;
      end else begin
        err_inc_c = 1'b1;
      end
    end

    if (err_inc_c && err_cnt != '1) begin
      err_nxt = err_cnt + ERR_W'(1);
    end

    stale_nxt = (stale_cnt_nxt >= STALE_FRAMES);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_q        <= '0;
      tx_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      stale_cnt_q <= STALE_FRAMES;
      stale       <= 1'b1;
      err_cnt     <= '0;
      q           <= '0;
      q_valid     <= 1'b0;
    end else begin
      rx_q        <= rx_nxt;
      tx_q        <= tx_nxt;
      pend_q      <= pend_nxt;
      pend_full_q <= pend_full_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      tmo_q       <= tmo_nxt;
      stale_cnt_q <= stale_cnt_nxt;
      stale       <= stale_nxt;
      err_cnt     <= err_nxt;
      q           <= q_nxt;
      q_valid     <= q_valid_nxt;
    end
  end

  assign sdi = tx_q[WORD_W-1];

endmodule
